// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter and fetch stage for a 1024x32 instruction memory.
// Drives the word address, captures the combinationally read instruction into an
// instruction register, and presents it to decode with a valid flag. It handles
// sequential fetch, redirect, stall, a post-reset boot delay, and halt/resume.
//
// Optional feature: define INSTRUCTION_FETCH_COUNT_EN to build the delivered-instruction
// counter on fetch_count. Without it, fetch_count is tied to zero.
//
// Ports:
//   clock            in   sole clock, posedge
//   reset            in   synchronous, active-high
//   instr_in         in   32-bit word read from memory at addy, same cycle
//   stall            in   decode not ready; hold PC and IR
//   redirect         in   one-cycle flow change request
//   redirect_target  in   new PC when redirect is high
//   resume           in   one-cycle request to leave HALT
//   addy             out  memory address, equal to the PC register
//   ir               out  registered instruction
//   ir_pc            out  address ir was fetched from
//   ir_valid         out  ir holds a live instruction
//   halted           out  fetch is halted
//   fetch_count      out  instructions delivered (0 unless counter enabled)
module instruction_fetch #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BOOT_CYCLES = 1,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr_in,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              resume,
    output logic [ADDR_W-1:0] addy,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    localparam int unsigned BOOT_W    = 4;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              r_state;
    logic [BOOT_W-1:0]   r_boot_cnt;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic [ADDR_W-1:0]   r_ir_pc;
    logic                r_ir_valid;
    logic                r_halted;

    state_t              w_state_nxt;
    logic [BOOT_W-1:0]   w_boot_cnt_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [31:0]         w_ir_nxt;
    logic [ADDR_W-1:0]   w_ir_pc_nxt;
    logic                w_ir_valid_nxt;
    logic [ADDR_W-1:0]   w_pc_inc;

    assign w_pc_inc = r_pc + ADDR_W'(1);

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_boot_cnt <= '0;
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_boot_cnt <= w_boot_cnt_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_ir_pc    <= w_ir_pc_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_halted   <= (w_state_nxt == S_HALT);
        end
    end

    // Next-state and datapath selection; redirect outranks stall and halt detection
    always_comb begin
        w_state_nxt    = r_state;
        w_boot_cnt_nxt = r_boot_cnt;
        w_pc_nxt       = r_pc;
        w_ir_nxt       = r_ir;
        w_ir_pc_nxt    = r_ir_pc;
        w_ir_valid_nxt = r_ir_valid;

        unique case (r_state)
            S_BOOT: begin
                // Memory is initialising; all requests are ignored here
                w_pc_nxt       = '0;
                w_ir_valid_nxt = 1'b0;
                if (r_boot_cnt == BOOT_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_boot_cnt_nxt = r_boot_cnt + BOOT_W'(1);
                end
            end
            S_RUN: begin
                if (redirect) begin
                    w_pc_nxt       = redirect_target;
                    w_ir_valid_nxt = 1'b0;
                end else if (!stall) begin
                    w_ir_nxt       = instr_in;
                    w_ir_pc_nxt    = r_pc;
                    w_ir_valid_nxt = 1'b1;
                    if (instr_in[31:26] == HALT_OPCODE) begin
                        // PC parks on the halt instruction so resume continues after it
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            S_HALT: begin
                w_ir_valid_nxt = 1'b0;
                if (redirect) begin
                    w_pc_nxt    = redirect_target;
                    w_state_nxt = S_RUN;
                end else if (resume) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

`ifdef INSTRUCTION_FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    // Counts every RUN capture, including the halt instruction itself
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if ((r_state == S_RUN) && !redirect && !stall) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    assign fetch_count = '0;
`endif

    assign addy     = r_pc;
    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;
    assign halted   = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed walk through the fetch scenarios followed by
// randomized stall/redirect/resume/reset traffic, all compared every cycle against a
// behavioural model of the fetch stage driven from a memory array.
module tb_instruction_fetch;

    localparam int unsigned AW   = 10;
    localparam int unsigned BOOT = 1;
    localparam int unsigned MEM_WORDS = 1024;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   instr_in;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic          resume;
    logic [AW-1:0] addy;
    logic [31:0]   ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          halted;
    logic [31:0]   fetch_count;

    logic [31:0] mem [MEM_WORDS];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_mode;
    int          m_boot_left;
    int          m_pc;
    logic [31:0] m_ir;
    int          m_ir_pc;
    logic        m_valid;
    logic [31:0] m_count;

    always #5 clock = ~clock;

    assign instr_in = mem[addy];

    instruction_fetch #(
        .ADDR_W      (AW),
        .BOOT_CYCLES (BOOT),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .instr_in        (instr_in),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .resume          (resume),
        .addy            (addy),
        .ir              (ir),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic [31:0] word;
        word = mem[m_pc];
        if (reset) begin
            m_mode      = M_BOOT;
            m_boot_left = BOOT;
            m_pc        = 0;
            m_ir        = '0;
            m_ir_pc     = 0;
            m_valid     = 1'b0;
            m_count     = '0;
        end else begin
            case (m_mode)
                M_BOOT: begin
                    m_pc    = 0;
                    m_valid = 1'b0;
                    m_boot_left = m_boot_left - 1;
                    if (m_boot_left == 0) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (redirect) begin
                        m_pc    = int'(redirect_target);
                        m_valid = 1'b0;
                    end else if (!stall) begin
                        m_ir    = word;
                        m_ir_pc = m_pc;
                        m_valid = 1'b1;
                        m_count = m_count + 32'd1;
                        if ((word >> 26) == 32'h3F) m_mode = M_HALT;
                        else m_pc = (m_pc + 1) % MEM_WORDS;
                    end
                end
                default: begin
                    m_valid = 1'b0;
                    if (redirect) begin
                        m_pc   = int'(redirect_target);
                        m_mode = M_RUN;
                    end else if (resume) begin
                        m_pc   = (m_pc + 1) % MEM_WORDS;
                        m_mode = M_RUN;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        check("addy", 32'(addy), 32'(m_pc));
        check("ir", ir, m_ir);
        check("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
        check("ir_valid", 32'(ir_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_mode == M_HALT));
`ifdef INSTRUCTION_FETCH_COUNT_EN
        check("fetch_count", fetch_count, m_count);
`else
        check("fetch_count", fetch_count, 32'd0);
`endif
    endtask

    // One clock: model update, edge, then sample just after the edge
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic drive(input logic rst, input logic stl, input logic rdr,
                         input logic [AW-1:0] tgt, input logic rsm);
        reset           = rst;
        stall           = stl;
        redirect        = rdr;
        redirect_target = tgt;
        resume          = rsm;
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0400_0000 + 32'(i);
        mem[0] = 32'h5800_0000;
        mem[1] = 32'h5804_0000;
        mem[2] = 32'h1111_1111;
        mem[3] = 32'h2222_2222;
        mem[4] = 32'h3333_3333;
        mem[5] = 32'hFC00_0000;
        mem[6] = 32'h4444_4444;
        mem[10'h200] = 32'hABCD_0200;
        mem[1023]    = 32'h1234_03FF;

        m_mode = M_BOOT; m_boot_left = BOOT; m_pc = 0; m_ir = '0;
        m_ir_pc = 0; m_valid = 1'b0; m_count = '0;

        // Reset, then sequential run
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        tick(); tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();                                  // end of cycle 0: boot
        check("boot_valid", 32'(ir_valid), 32'd0);
        tick();                                  // fetch of address 0
        check("first_ir", ir, 32'h5800_0000);
        check("first_valid", 32'(ir_valid), 32'd1);
        tick();                                  // fetch of address 1
        check("seq_ir_pc1", 32'(ir_pc), 32'd1);

        // Stall three cycles while ir_pc=1
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addy", 32'(addy), 32'd2);
            check("stall_ir", ir, 32'h5804_0000);
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("post_stall_ir_pc", 32'(ir_pc), 32'd2);
`ifdef INSTRUCTION_FETCH_COUNT_EN
        check("count3", fetch_count, 32'd3);
`endif

        // Run into the halt at address 5
        tick(); tick(); tick();
        check("halt_ir", ir, 32'hFC00_0000);
        check("halt_flag", 32'(halted), 32'd1);
        tick();
        check("halt_invalid", 32'(ir_valid), 32'd0);
        check("halt_addy", 32'(addy), 32'd5);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0);        // stall ignored in halt
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        tick();
        check("resume_addy", 32'(addy), 32'd6);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("resume_ir_pc", 32'(ir_pc), 32'd6);

        // Redirect together with stall
        drive(1'b0, 1'b1, 1'b1, AW'(10'h200), 1'b0);
        tick();
        check("rdr_addy", 32'(addy), 32'h200);
        check("rdr_flush", 32'(ir_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("rdr_ir_pc", 32'(ir_pc), 32'h200);

        // Wrap at the top of memory
        drive(1'b0, 1'b0, 1'b1, AW'(10'd1023), 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        check("wrap_ir_pc", 32'(ir_pc), 32'd1023);
        check("wrap_addy", 32'(addy), 32'd0);

        // Reach HALT again, then reset from HALT
        drive(1'b0, 1'b0, 1'b1, AW'(10'd5), 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick(); tick();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        tick();
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_ir", ir, 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick(); tick();
        check("restart_ir_pc", 32'(ir_pc), 32'd0);
        check("restart_valid", 32'(ir_valid), 32'd1);

        // Randomized traffic over a memory sprinkled with halts
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = $urandom();
            if ($urandom_range(19) == 0) mem[i][31:26] = 6'h3F;
            else if (mem[i][31:26] == 6'h3F) mem[i][31:26] = 6'h00;
        end
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(99) == 0,
                  $urandom_range(9) < 3,
                  $urandom_range(9) == 0,
                  AW'($urandom_range(MEM_WORDS - 1)),
                  $urandom_range(4) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
